// File: rtl/fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_scheduler
// Description : Round-robin scheduler that time-shares one combinational
//               single-precision adder between NUM_REQ requesters. It grants
//               one requester, registers its operands, captures the sum and
//               returns it with the requester ID over a valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [31:0]     op_a;
    logic [31:0]     op_b;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            accept;
    logic [ID_W-1:0] ptr_nxt;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign accept  = (state == IDLE) && grant_found;
    assign ptr_nxt = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = COMPUTE;
            COMPUTE: state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: one-hot accept strobe only in IDLE, busy otherwise
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        busy = (state != IDLE);
    end

    // Datapath registers: operands and ID on accept, sum in COMPUTE, count on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                op_a    <= sel_a;
                op_b    <= sel_b;
                resp_id <= grant_idx;
                rr_ptr  <= ptr_nxt;
            end
            if (state == COMPUTE) begin
                resp_data  <= add_result;
                resp_valid <= 1'b1;
            end
            if ((state == RESP) && resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                op_count   <= op_count + 1'b1;
            end
        end
    end

    // Adder inputs always come straight from the operand registers
    assign add_a = op_a;
    assign add_b = op_b;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_scheduler
// Description : Directed, table-driven bench for fp_add_scheduler. Provides a
//               behavioural adder for positive normal operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  resp_ready;

    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           add_a, add_b, add_result;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;
    logic [15:0]           op_count;

    logic [NUM_REQ-1:0]    req_ready4;
    logic [31:0]           add_a4, add_b4, add_result4;
    logic                  resp_valid4;
    logic [31:0]           resp_data4;
    logic [ID_W-1:0]       resp_id4;
    logic                  busy4;
    logic [3:0]            op_count4;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    // Behavioural adder: positive normals, truncating
    function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b;
        logic [7:0]  ea, eb, d;
        logic [24:0] ma, mb, s;
        a = a_in;
        b = b_in;
        if (b_in[30:23] > a_in[30:23]) begin
            a = b_in;
            b = a_in;
        end
        ea = a[30:23];
        eb = b[30:23];
        d  = ea - eb;
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        mb = (d > 8'd24) ? 25'd0 : (mb >> d);
        s  = ma + mb;
        if (s[24]) return {1'b0, ea + 8'd1, s[23:1]};
        return {1'b0, ea, s[22:0]};
    endfunction

    assign add_result  = fadd(add_a, add_b);
    assign add_result4 = fadd(add_a4, add_b4);

    fp_add_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .busy(busy), .op_count(op_count)
    );

    fp_add_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready4), .add_a(add_a4), .add_b(add_b4), .add_result(add_result4),
        .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_data(resp_data4),
        .resp_id(resp_id4), .busy(busy4), .op_count(op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    // One full operation from IDLE with resp_ready high; inputs already set
    task automatic do_op(input int gid, input logic [31:0] sum, input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'(1 << gid));
        check({tag, " busy idle"}, 32'(busy), 32'd0);
        step();
        check({tag, " busy compute"}, 32'(busy), 32'd1);
        check({tag, " resp_valid compute"}, 32'(resp_valid), 32'd0);
        step();
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_data"}, resp_data, sum);
        check({tag, " resp_id"}, 32'(resp_id), 32'(gid));
        step();
        exp_count++;
        check({tag, " op_count"}, 32'(op_count), 32'(exp_count));
        check({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] rr_sum[4];
    int rr_order[6];

    initial begin
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000}; // 1+2=3
        vecs[1] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40400000}; // 1.5+1.5=3
        vecs[2] = '{2, 32'h40000000, 32'h40000000, 32'h40800000}; // 2+2=4
        vecs[3] = '{3, 32'h3F800000, 32'h3F800000, 32'h40000000}; // 1+1=2
        vecs[4] = '{3, 32'h40400000, 32'h3F800000, 32'h40800000}; // 3+1=4
        rr_order = '{0, 1, 2, 3, 0, 1};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
        step();
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset op_count", 32'(op_count), 32'd0);
        check("reset add_a", add_a, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle req_ready none", 32'(req_ready), 32'd0);

        // Single requests from the table
        for (int v = 0; v < 5; v++) begin
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid = 4'(1 << vecs[v].id);
            #1;
            check("single add_a pre", add_a, (v == 0) ? 32'd0 : vecs[v-1].a);
            do_op(vecs[v].id, vecs[v].sum, $sformatf("single%0d", v));
            req_valid = '0;
        end

        // Round robin: all four requesting continuously (rr_ptr is 0 now)
        set_op(0, 32'h3F800000, 32'h40000000); rr_sum[0] = 32'h40400000;
        set_op(1, 32'h40000000, 32'h40000000); rr_sum[1] = 32'h40800000;
        set_op(2, 32'h3FC00000, 32'h3FC00000); rr_sum[2] = 32'h40400000;
        set_op(3, 32'h3F800000, 32'h3F800000); rr_sum[3] = 32'h40000000;
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 6; g++) begin
            do_op(rr_order[g], rr_sum[rr_order[g]], $sformatf("rr%0d", g));
        end
        req_valid = '0;

        // Backpressure: grant req0, then hold response for 5 cycles with req1 waiting
        resp_ready = 1'b0;
        set_op(0, 32'h3F800000, 32'h3F800000);
        set_op(1, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'b0001;
        #1;
        check("bp grant0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp resp_valid", 32'(resp_valid), 32'd1);
            check("bp resp_data", resp_data, 32'h40000000);
            check("bp resp_id", 32'(resp_id), 32'd0);
            check("bp req_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("bp still valid", 32'(resp_valid), 32'd1);
        step();
        exp_count++;
        check("bp op_count", 32'(op_count), 32'(exp_count));
        check("bp resp_valid drop", 32'(resp_valid), 32'd0);
        do_op(1, 32'h40400000, "bp req1");
        req_valid = '0;

        // Pointer rotation (rr_ptr now 2): only req3, then req0 and req3
        req_valid = 4'b1000;
        #1;
        do_op(3, 32'h40000000, "rot3");
        req_valid = 4'b1001;
        #1;
        do_op(0, 32'h40000000, "rot0");
        do_op(3, 32'h40000000, "rot3b");
        req_valid = '0;

        // Reset during COMPUTE after granting req2 (which moves rr_ptr to 3)
        req_valid = 4'b0100;
        #1;
        check("rst grant2", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        check("rst in compute", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst async resp_valid", 32'(resp_valid), 32'd0);
        check("rst async busy", 32'(busy), 32'd0);
        check("rst async op_count", 32'(op_count), 32'd0);
        exp_count = 0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst no resp", 32'(resp_valid), 32'd0);
        end
        set_op(1, 32'h3F800000, 32'h40000000);
        set_op(3, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b1010;
        #1;
        do_op(1, 32'h40400000, "post rst");
        req_valid = '0;

        // Counter wrap: 16 more ops makes 17 since reset
        set_op(0, 32'h40000000, 32'h40000000);
        req_valid = 4'b0001;
        for (int n = 0; n < 16; n++) begin
            #1;
            do_op(0, 32'h40800000, $sformatf("wrap%0d", n));
        end
        req_valid = '0;
        check("wrap op_count cnt4", 32'(op_count4), 32'd1);
        check("wrap op_count cnt16", 32'(op_count), 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
